// File: rtl/ur_burst_arb.sv
// Round-robin burst read arbiter in front of the unified RAM.
// Optional per-requester beat statistics: define UR_BURST_ARB_STATS_EN.
module ur_burst_arb #(
  parameter int NUM_REQ    = 6,
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 128,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
  output logic                          ur_re,
  output logic [3:0]                    ur_id,
  output logic [ADDR_WIDTH-1:0]         ur_addr,
  input  logic [DATA_WIDTH-1:0]         ur_rdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_last,
  output logic                          busy,
  input  logic [3:0]                    stat_sel,
  output logic [31:0]                   stat_beats
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  logic [3:0]              rr_ptr_q, rr_ptr_d;
  logic [3:0]              owner_q, owner_d;
  logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
  logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic                    rsp_last_q, rsp_last_d;

  logic [2*NUM_REQ-1:0]    req_rot;
  logic                    grant_found;
  logic [4:0]              grant_sum;
  logic [3:0]              grant_idx;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [LEN_WIDTH-1:0]    sel_len;

  // Rotating the doubled request vector puts rr_ptr at bit 0, so the
  // lowest set bit is the next requester in round-robin order.
  assign req_rot = {req_valid, req_valid} >> rr_ptr_q;

  always_comb begin
    grant_found = 1'b0;
    grant_sum   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req_rot[i]) begin
        grant_found = 1'b1;
        grant_sum   = {1'b0, rr_ptr_q} + 5'(i);
      end
    end
    if (grant_sum >= 5'(NUM_REQ)) grant_sum = grant_sum - 5'(NUM_REQ);
    grant_idx = grant_sum[3:0];
  end

  always_comb begin
    sel_addr  = '0;
    sel_len   = '0;
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == 4'(i)) begin
        sel_addr     = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len      = req_len[i*LEN_WIDTH +: LEN_WIDTH];
        req_ready[i] = rst_n && (state_q == IDLE) && grant_found;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    cur_addr_d  = cur_addr_q;
    cnt_d       = cnt_q;
    rsp_valid_d = '0;
    rsp_last_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          owner_d    = grant_idx;
          cur_addr_d = sel_addr;
          cnt_d      = sel_len;
          rr_ptr_d   = (grant_idx == 4'(NUM_REQ-1)) ? 4'd0 : grant_idx + 4'd1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        cur_addr_d  = cur_addr_q + 1'b1;
        rsp_valid_d = ONE_HOT0 << owner_q;
        rsp_last_d  = (cnt_q == '0);
        if (cnt_q == '0) state_d = DRAIN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      cur_addr_q  <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      cur_addr_q  <= cur_addr_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

  // Busy covers the accept cycle as well, so a burst reads as N+2 busy cycles.
  assign ur_re     = (state_q == ISSUE);
  assign ur_id     = ur_re ? owner_q : '0;
  assign ur_addr   = ur_re ? cur_addr_q : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_data  = ur_rdata;
  assign busy      = (state_q != IDLE) || (|req_ready);

`ifdef UR_BURST_ARB_STATS_EN
  logic [31:0] beats_q [NUM_REQ];
  logic [31:0] beats_d [NUM_REQ];
  logic [31:0] stat_q, stat_d;

  always_comb begin
    stat_d = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      beats_d[i] = beats_q[i];
      if (rsp_valid_q[i] && (beats_q[i] != '1)) beats_d[i] = beats_q[i] + 32'd1;
      if (stat_sel == 4'(i)) stat_d = beats_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) beats_q[i] <= '0;
      stat_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) beats_q[i] <= beats_d[i];
      stat_q <= stat_d;
    end
  end

  assign stat_beats = stat_q;
`else
  logic stat_sel_unused;
  assign stat_sel_unused = ^stat_sel;
  assign stat_beats      = '0;
`endif

endmodule

// File: tb/tb_ur_burst_arb.sv
// Scoreboard bench for ur_burst_arb: stimulus pushes expected RAM commands
// and response beats; a negedge monitor pops and compares them.
module tb_ur_burst_arb;

  localparam int NR = 6;
  localparam int AW = 11;
  localparam int DW = 128;
  localparam int LW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*AW-1:0] req_addr;
  logic [NR*LW-1:0] req_len;
  logic            ur_re;
  logic [3:0]      ur_id;
  logic [AW-1:0]   ur_addr;
  logic [DW-1:0]   ur_rdata;
  logic [NR-1:0]   rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            rsp_last;
  logic            busy;
  logic [3:0]      stat_sel;
  logic [31:0]     stat_beats;

  ur_burst_arb #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len), .ur_re(ur_re), .ur_id(ur_id),
    .ur_addr(ur_addr), .ur_rdata(ur_rdata), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_last(rsp_last), .busy(busy),
    .stat_sel(stat_sel), .stat_beats(stat_beats)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {a, 5'h00, ~a, 5'h01, 96'hDEAD_BEEF_0123_4567_89AB_CDEF};
  endfunction

  // RAM model: data for the commanded address appears one cycle later.
  always @(posedge clk) if (ur_re) ur_rdata <= pat(ur_addr);

  typedef struct { int cyc; logic [3:0] id; logic [AW-1:0] addr; } cmd_t;
  typedef struct { int cyc; logic [NR-1:0] vld; logic last; logic [DW-1:0] data; } rsp_t;
  cmd_t cmd_q[$];
  rsp_t rsp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_burst(input int id, input logic [AW-1:0] a, input logic [LW-1:0] l, input int acc);
    for (int k = 0; k <= int'(l); k++) begin
      cmd_t c;
      rsp_t r;
      c.cyc = acc + 1 + k; c.id = 4'(id); c.addr = a + AW'(k);
      r.cyc = acc + 2 + k; r.vld = NR'(1) << id; r.last = (k == int'(l)); r.data = pat(c.addr);
      cmd_q.push_back(c);
      rsp_q.push_back(r);
    end
  endtask

  always @(negedge clk) begin
    if (ur_re) begin
      if (cmd_q.size() == 0) check("cmd_unexpected", 1, 0);
      else begin
        cmd_t c;
        c = cmd_q.pop_front();
        check("cmd_cycle", cyc, c.cyc);
        check("cmd_id", ur_id, c.id);
        check("cmd_addr", ur_addr, c.addr);
      end
    end else if (rst_n) begin
      check("idle_cmd_zero", {ur_id, ur_addr}, 0);
    end
    if (rsp_valid != '0) begin
      if (rsp_q.size() == 0) check("rsp_unexpected", rsp_valid, 0);
      else begin
        rsp_t r;
        r = rsp_q.pop_front();
        check("rsp_cycle", cyc, r.cyc);
        check("rsp_valid", rsp_valid, r.vld);
        check("rsp_last", rsp_last, r.last);
        check("rsp_data", rsp_data, r.data);
      end
    end
  end

  // Starts at a negedge; returns at the negedge after accept.
  task automatic request(input int id, input logic [AW-1:0] a, input logic [LW-1:0] l, output int acc);
    bit got = 0;
    acc = -1;
    req_addr[id*AW +: AW] = a;
    req_len[id*LW +: LW]  = l;
    req_valid[id]         = 1'b1;
    for (int t = 0; t < 40 && !got; t++) begin
      #1;
      if (req_ready != '0) begin
        got = 1;
        acc = cyc;
        check("grant", req_ready, NR'(1) << id);
        check("busy_on_accept", busy, 1);
        push_burst(id, a, l, acc);
      end
      @(negedge clk);
    end
    if (!got) check("grant_timeout", 0, 1);
    req_valid[id] = 1'b0;
  endtask

  // Counts busy cycles including the accept cycle already seen.
  task automatic wait_idle(input string name, input int exp_busy);
    int n = 1;
    for (int t = 0; t < 60; t++) begin
      #1;
      if (!busy) break;
      n++;
      @(negedge clk);
    end
    check(name, n, exp_busy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    cmd_q.delete();
    rsp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  int acc;
  int c0;
  int nxt;
  logic [NR-1:0] g;

  initial begin
    rst_n     = 1'b0;
    req_valid = '1;
    req_addr  = '0;
    req_len   = '0;
    stat_sel  = 4'd0;
    ur_rdata  = '0;
    #3;
    check("rst_ready", req_ready, 0);
    check("rst_outputs", {ur_re, ur_id, ur_addr, rsp_valid, rsp_last, busy}, 0);
    check("rst_stat", stat_beats, 0);
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single burst: 4 beats from 0x020, owner 2, six busy cycles.
    request(2, 11'h020, 8'd3, acc);
    wait_idle("busy_len3", 6);
    @(negedge clk);

    // Address wrap 0x7FE, 0x7FF, 0x000.
    request(4, 11'h7FE, 8'd2, acc);
    wait_idle("busy_wrap", 5);
    @(negedge clk);

    // Round-robin from requester 0, one grant every 3 cycles.
    do_reset();
    for (int k = 0; k < NR; k++) begin
      req_addr[k*AW +: AW] = AW'(11'h040 + k);
      req_len[k*LW +: LW]  = '0;
    end
    req_valid = '1;
    nxt = 0;
    c0  = 0;
    for (int t = 0; t < 80 && nxt < NR; t++) begin
      #1;
      if (req_ready != '0) begin
        if (nxt == 0) c0 = cyc;
        check("rr_grant", req_ready, NR'(1) << nxt);
        check("rr_spacing", cyc, c0 + 3 * nxt);
        push_burst(nxt, AW'(11'h040 + nxt), '0, cyc);
        g = req_ready;
        nxt++;
        @(negedge clk);
        req_valid = req_valid & ~g;
      end else begin
        @(negedge clk);
      end
    end
    check("rr_all_granted", nxt, NR);
    req_valid = '0;
    wait_idle("busy_rr_tail", 3);
    @(negedge clk);

    // Reset during the second beat of an 8-beat burst.
    request(3, 11'h100, 8'd7, acc);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    cmd_q.delete();
    rsp_q.delete();
    check("midrst_outputs", {ur_re, ur_id, ur_addr, rsp_valid, rsp_last, busy, req_ready}, 0);
    check("midrst_stat", stat_beats, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_quiet", {ur_re, rsp_valid}, 0);
    request(5, 11'h3A0, 8'd1, acc);
    wait_idle("busy_post_rst", 4);
    @(negedge clk);

    // Beat statistics.
    do_reset();
    request(1, 11'h200, 8'd3, acc);
    wait_idle("busy_stat_a", 6);
    @(negedge clk);
    request(1, 11'h210, 8'd0, acc);
    wait_idle("busy_stat_b", 3);
    stat_sel = 4'd1;
    repeat (3) @(negedge clk);
`ifdef UR_BURST_ARB_STATS_EN
    check("stat_req1", stat_beats, 5);
`else
    check("stat_req1", stat_beats, 0);
`endif
    stat_sel = 4'd9;
    repeat (2) @(negedge clk);
    check("stat_sel9", stat_beats, 0);

    repeat (3) @(negedge clk);
    check("cmd_queue_empty", cmd_q.size(), 0);
    check("rsp_queue_empty", rsp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=0", cyc);
    $fatal(1);
  end

endmodule

// File: doc/ur_burst_arb.md
UR_BURST_ARB -- requirements
Module: ur_burst_arb

Interface
REQ-001 The block SHALL take parameter NUM_REQ, default 6: number of burst requesters, legal range 2..16.
REQ-002 The block SHALL take parameter ADDR_WIDTH, default 11: unified-RAM word address width.
REQ-003 The block SHALL take parameter DATA_WIDTH, default 128: read data width.
REQ-004 The block SHALL take parameter LEN_WIDTH, default 8: burst length field width.
REQ-005 The block SHALL provide port clk, input, 1: clock; all logic on its rising edge.
REQ-006 The block SHALL provide port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 The block SHALL provide port req_valid, input, NUM_REQ: per-requester burst request.
REQ-008 The block SHALL provide port req_ready, output, NUM_REQ: per-requester accept, at most one bit high.
REQ-009 The block SHALL provide port req_addr, input, NUM_REQ*ADDR_WIDTH: packed start addresses; requester i uses slice i.
REQ-010 The block SHALL provide port req_len, input, NUM_REQ*LEN_WIDTH: packed burst lengths; beats = req_len+1.
REQ-011 The block SHALL provide ports ur_re (output, 1), ur_id (output, 4) and ur_addr (output, ADDR_WIDTH): the RAM read command.
REQ-012 The block SHALL provide port ur_rdata, input, DATA_WIDTH: RAM read data, valid one cycle after ur_re.
REQ-013 The block SHALL provide ports rsp_valid (output, NUM_REQ), rsp_data (output, DATA_WIDTH) and rsp_last (output, 1): the returned beat.
REQ-014 The block SHALL provide port busy, output, 1: high whenever state is not IDLE.
REQ-015 The block SHALL provide ports stat_sel (input, 4) and stat_beats (output, 32): the beat-count readout.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ISSUE and DRAIN.
REQ-017 In IDLE with any req_valid high, the block SHALL grant the first valid requester found by searching upward from rr_ptr, wrapping from NUM_REQ-1 to 0.
REQ-018 req_ready SHALL be combinational: high only for the winner, only in IDLE.
REQ-019 On the accept cycle, the block SHALL latch owner, start address and beat count, set rr_ptr to (winner+1) mod NUM_REQ, and move to ISSUE.
REQ-020 In ISSUE, every cycle the block SHALL drive ur_re=1, ur_id=owner, ur_addr=cur_addr, then increment cur_addr modulo 2^ADDR_WIDTH, wrapping 0x7FF to 0x000 with no error.
REQ-021 After issuing the final beat, the block SHALL move from ISSUE to DRAIN; DRAIN SHALL last one cycle and then return to IDLE.
REQ-022 A burst of N beats SHALL occupy N+2 cycles: accept, N issue cycles, one drain cycle; no new grant before IDLE.
REQ-023 The block SHALL raise rsp_valid[owner] exactly one cycle after each ur_re.
REQ-024 rsp_data SHALL equal ur_rdata, passed through combinationally.
REQ-025 rsp_last SHALL be high with the final beat only.
REQ-026 First-beat latency SHALL be 2 cycles from accept to rsp_valid.
REQ-027 A requester SHALL hold req_valid, req_addr and req_len stable until accepted; the block samples them only on accept.
REQ-028 A requester dropping req_valid before accept SHALL be skipped without side effects.
REQ-029 req_len=0 SHALL yield a single beat with rsp_last set.
REQ-030 Outside ISSUE, the block SHALL hold ur_re, ur_id and ur_addr at 0.

Reset
REQ-031 Asserting rst_n low at any time, including mid-burst, SHALL immediately force: state IDLE; rr_ptr 0; req_ready, rsp_valid, rsp_last, ur_re, ur_id, ur_addr, busy and stat_beats 0; counters 0.
REQ-032 Any in-flight burst SHALL be abandoned with no further rsp_valid.
REQ-033 The first grant after reset release SHALL search from requester 0.

Configuration
REQ-034 With UR_BURST_ARB_STATS_EN defined, the block SHALL keep a 32-bit saturating beat counter per requester, incremented on each rsp_valid.
REQ-035 With UR_BURST_ARB_STATS_EN defined, stat_beats SHALL return the counter selected by stat_sel, registered with 1-cycle latency; a stat_sel value of NUM_REQ or above SHALL return 0.
REQ-036 Without UR_BURST_ARB_STATS_EN, no counters SHALL exist, stat_beats SHALL be tied to 0, and all other behaviour SHALL be identical.

Verification
REQ-037 Single request: req 2, addr 0x020, len 3 -> ur_re for 4 cycles, addresses 0x020..0x023, ur_id=2; rsp_valid[2] for 4 cycles starting 2 cycles after accept; rsp_last on the 4th beat; busy for 6 cycles.
REQ-038 Wrap: addr 0x7FE, len 2 -> ur_addr sequence 0x7FE, 0x7FF, 0x000.
REQ-039 Round-robin: all 6 requesters valid with len 0 -> grant order 0,1,2,3,4,5, one grant every 3 cycles.
REQ-040 Reset mid-burst: assert rst_n low during the 2nd beat of a len-7 burst -> all outputs 0 immediately; after release, a request from requester 5 gets its first ur_re 1 cycle after accept.
REQ-041 Stats (UR_BURST_ARB_STATS_EN): req 1 len 3, then req 1 len 0 -> stat_sel=1 reads 5, stat_sel=9 reads 0; built without the macro, stat_beats reads 0.
